// File: rtl/tt_user_pkg.sv
// Shared types and constants for the tt_user_top accumulator tile.
package tt_user_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FLAG_W = 4;

  // Bit positions inside the flag nibble shown as {Z,N,C,V}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_LOADI = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_STORE = 3'd6,
    OP_LOADR = 3'd7
  } opcode_t;

endpackage

// File: rtl/tt_alu8.sv
// Combinational 8-bit ALU: computes the next accumulator value and carry/overflow.
module tt_alu8
  import tt_user_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  opcode_t           opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              overflow,
  output logic              writes_acc,
  output logic              updates_cv
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  // Extended add/subtract so the top bit is the carry-out / borrow
  always_comb begin
    sum_ext  = {1'b0, acc} + {1'b0, operand};
    diff_ext = {1'b0, acc} - {1'b0, operand};
  end

  // Opcode decode; LOADR expects the register value on the operand input
  always_comb begin
    result     = acc;
    carry      = 1'b0;
    overflow   = 1'b0;
    writes_acc = 1'b1;
    updates_cv = 1'b0;
    case (opcode)
      OP_LOADI: result = operand;
      OP_ADD: begin
        result     = sum_ext[DATA_W-1:0];
        carry      = sum_ext[DATA_W];
        overflow   = (acc[DATA_W-1] == operand[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != acc[DATA_W-1]);
        updates_cv = 1'b1;
      end
      OP_SUB: begin
        result     = diff_ext[DATA_W-1:0];
        carry      = diff_ext[DATA_W];
        overflow   = (acc[DATA_W-1] != operand[DATA_W-1]) &&
                     (diff_ext[DATA_W-1] != acc[DATA_W-1]);
        updates_cv = 1'b1;
      end
      OP_AND:   result = acc & operand;
      OP_OR:    result = acc | operand;
      OP_XOR:   result = acc ^ operand;
      OP_STORE: writes_acc = 1'b0;
      OP_LOADR: result = operand;
      default:  writes_acc = 1'b0;
    endcase
  end

endmodule

// File: rtl/tt_user_top.sv
// Accumulator tile: strobed command decode, register file, flags, command counter.
module tt_user_top
  import tt_user_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  ui_in,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uo_out,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rf [NREGS];
  logic [FLAG_W-1:0] flags;
  logic [CNT_W-1:0]  cnt;
  logic              strobe_q;

  opcode_t           opcode;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_overflow;
  logic              alu_writes_acc;
  logic              alu_updates_cv;
  logic              fire;
  logic              unused_bits;

  // Field extraction and rising-strobe qualification
  always_comb begin
    opcode      = opcode_t'(ui_in[3:1]);
    sel         = ui_in[5:4];
    alu_operand = (opcode == OP_LOADR) ? rf[sel] : uio_in;
    fire        = ui_in[0] & ~strobe_q & ena;
    unused_bits = ui_in[6];
  end

  tt_alu8 u_alu (
    .acc        (acc),
    .operand    (alu_operand),
    .opcode     (opcode),
    .result     (alu_result),
    .carry      (alu_carry),
    .overflow   (alu_overflow),
    .writes_acc (alu_writes_acc),
    .updates_cv (alu_updates_cv)
  );

  // Architectural state; strobe_q resets high so a held strobe cannot fire on release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      flags    <= '0;
      cnt      <= '0;
      strobe_q <= 1'b1;
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else begin
      strobe_q <= ui_in[0];
      if (fire) begin
        cnt <= cnt + CNT_W'(1);
        if (opcode == OP_STORE) rf[sel] <= acc;
        if (alu_writes_acc) begin
          acc           <= alu_result;
          flags[FLAG_Z] <= (alu_result == '0);
          flags[FLAG_N] <= alu_result[DATA_W-1];
        end
        if (alu_updates_cv) begin
          flags[FLAG_C] <= alu_carry;
          flags[FLAG_V] <= alu_overflow;
        end
      end
    end
  end

  // View mux and constant bidirectional pin controls
  always_comb begin
    uo_out  = ui_in[7] ? {flags, cnt} : acc;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
  end

endmodule

// File: tb/tb_tt_user_top.sv
// Self-checking bench for tt_user_top: directed scenarios plus randomized traffic.
module tb_tt_user_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h01;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // Reference state as plain integers
  int m_acc = 0;
  int m_r[4] = '{0, 0, 0, 0};
  int m_z = 0, m_n = 0, m_c = 0, m_v = 0, m_cnt = 0;
  int m_sq = 1;

  tt_user_top dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic int view1();
    return m_z * 128 + m_n * 64 + m_c * 32 + m_v * 16 + m_cnt;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: executes a command on each qualified rising strobe
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc = 0; m_r = '{0, 0, 0, 0};
      m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_cnt = 0;
      m_sq = 1;
    end else begin
      if (ui_in[0] && m_sq == 0 && ena) begin
        int op, sel, b, s;
        op  = int'(ui_in[3:1]);
        sel = int'(ui_in[5:4]);
        b   = int'(uio_in);
        m_cnt = (m_cnt + 1) % 16;
        case (op)
          0: m_acc = b;
          1: begin
            s     = sx(m_acc) + sx(b);
            m_c   = (m_acc + b > 255) ? 1 : 0;
            m_v   = (s > 127 || s < -128) ? 1 : 0;
            m_acc = (m_acc + b) % 256;
          end
          2: begin
            s     = sx(m_acc) - sx(b);
            m_c   = (m_acc < b) ? 1 : 0;
            m_v   = (s > 127 || s < -128) ? 1 : 0;
            m_acc = (m_acc - b + 256) % 256;
          end
          3: m_acc = m_acc & b;
          4: m_acc = m_acc | b;
          5: m_acc = m_acc ^ b;
          6: m_r[sel] = m_acc;
          default: m_acc = m_r[sel];
        endcase
        if (op != 6) begin
          m_z = (m_acc == 0) ? 1 : 0;
          m_n = (m_acc >= 128) ? 1 : 0;
        end
      end
      m_sq = int'(ui_in[0]);
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("uo_out", uo_out, ui_in[7] ? 8'(view1()) : 8'(m_acc));
      chk("uio_oe", uio_oe, 8'h00);
      chk("uio_out", uio_out, 8'h00);
    end
  end

  // One command: strobe high for one cycle, then low for one cycle
  task automatic cmd(input int op, input int sel, input int opd);
    @(posedge clk); #2;
    ui_in  = {1'b0, 1'b0, 2'(sel), 3'(op), 1'b1};
    uio_in = 8'(opd);
    @(posedge clk); #2;
    ui_in[0] = 1'b0;
  endtask

  // Literal expectation for a chosen view
  task automatic lit(input string name, input bit view, input logic [7:0] exp);
    @(posedge clk); #2;
    ui_in[7] = view;
    #1 chk(name, uo_out, exp);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1 checking = 1'b1;
    // Reset with strobe held high through release
    repeat (3) @(posedge clk);
    #2 ui_in[7] = 1'b0;
    #1 chk("reset_acc", uo_out, 8'h00);
    ui_in[7] = 1'b1;
    #1 chk("reset_view1", uo_out, 8'h00);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    lit("release_view1", 1'b1, 8'h00);
    lit("release_acc", 1'b0, 8'h00);
    @(posedge clk); #2 ui_in[0] = 1'b0;

    cmd(0, 0, 8'hF0); cmd(1, 0, 8'h20);
    lit("add_carry_acc", 1'b0, 8'h10);
    lit("add_carry_view1", 1'b1, 8'h22);

    cmd(0, 0, 8'h7F); cmd(1, 0, 8'h01);
    lit("add_ovf_acc", 1'b0, 8'h80);
    lit("add_ovf_view1", 1'b1, 8'h54);
    cmd(2, 0, 8'h80);
    lit("sub_zero_view1", 1'b1, 8'h85);

    cmd(0, 0, 8'h05); cmd(2, 0, 8'h06);
    lit("sub_borrow_acc", 1'b0, 8'hFF);
    lit("sub_borrow_view1", 1'b1, 8'h67);
    cmd(5, 0, 8'hFF);
    lit("xor_keep_c_view1", 1'b1, 8'hA8);

    cmd(0, 0, 8'hA5); cmd(6, 2, 8'h00);
    lit("store_flags_view1", 1'b1, 8'h6A);
    cmd(0, 0, 8'h00); cmd(7, 2, 8'h00);
    lit("loadr_acc", 1'b0, 8'hA5);
    lit("loadr_view1", 1'b1, 8'h6C);

    // Strobe held high for five cycles executes once
    @(posedge clk); #2;
    ui_in  = 8'b0000_0011;
    uio_in = 8'h01;
    repeat (5) @(posedge clk);
    #2 ui_in[0] = 1'b0;
    lit("held_strobe_view1", 1'b1, 8'h4D);

    // Rising strobe while disabled is lost
    ena = 1'b0;
    cmd(0, 0, 8'h33);
    @(posedge clk); #2 ena = 1'b1;
    lit("ena_low_acc", 1'b0, 8'hA6);

    cmd(3, 0, 8'h0F); cmd(4, 0, 8'h10); cmd(0, 0, 8'h00);
    lit("cnt_wrap_view1", 1'b1, 8'h80);

    // Randomized traffic with occasional mid-sequence resets
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      ui_in  = 8'($urandom);
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_user_top.md
Name: tt_user_top

Overview:
- Top-level user block for a TinyTapeout-style tile: an 8-bit accumulator datapath with a 4-entry register file, driven by a strobed command interface.
- Commands arrive on ui_in; the operand arrives on the uio pins, which are used as inputs only.
- uo_out shows either the accumulator or a status/count word, selected by ui_in[7].

Parameters:
- NREGS, 4, register-file depth; fixed at 4 because the select field is 2 bits.
- CNT_W, 4, width of the executed-command counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted); the name keeps the codebase's port name.
- ena  in  1  tile enable; while 0, commands are not executed.
- ui_in  in  8  [0] strobe, [3:1] opcode, [5:4] register select, [6] unused, [7] view select.
- uio_in  in  8  operand byte.
- uo_out  out  8  view 0 = ACC; view 1 = {Z,N,C,V,CNT[3:0]}.
- uio_out  out  8  constant 8'h00.
- uio_oe  out  8  constant 8'h00, so every uio pin is an input.

Behaviour:
- Reset, asynchronous while rst=0:
  - ACC=0, R0..R3=0, flags Z=N=C=V=0, CNT=0.
  - strobe_q=1, so a strobe held high through reset release does not fire.
  - Outputs go to their reset values immediately.
- Command detection:
  - A command executes on a rising edge of clk when ui_in[0]=1, strobe_q=0 and ena=1.
  - strobe_q <= ui_in[0] on every clock, regardless of ena.
  - Exactly one execution per 0->1 strobe transition.
  - A strobe held high executes once. A strobe rising while ena=0 is lost.
- Timing: opcode, select and operand are sampled on the executing edge. Results and flags are visible on uo_out after that edge (1-cycle latency).
- Opcodes (op = uio_in):
  - 000 LOADI: ACC<=op.
  - 001 ADD: {C,ACC}<=ACC+op; V = signed overflow (operands same sign, result sign differs).
  - 010 SUB: ACC<=ACC-op (mod 256); C=1 when ACC<op unsigned (borrow); V = signed overflow of subtraction.
  - 011 AND, 100 OR, 101 XOR: ACC<=ACC op uio_in.
  - 110 STORE: R[sel]<=ACC; ACC and flags unchanged.
  - 111 LOADR: ACC<=R[sel].
- Flags:
  - Z = (new ACC==0) and N = new ACC[7], updated by every ACC-writing opcode (all except STORE).
  - C and V are updated only by ADD and SUB; they are retained otherwise.
- CNT increments by 1 on every executed command, including STORE, and wraps 15->0.
- uo_out is a combinational mux on ui_in[7]; no latency on view switching.
- Reset asserted mid-sequence clears everything; the first command after release needs a fresh 0->1 strobe.

Decomposition:
- Package tt_user_pkg holds:
  - the opcode enum (OP_LOADI..OP_LOADR, 3 bits);
  - the flag-bit index constants;
  - NREGS and CNT_W.
- One sub-module, tt_alu8: purely combinational.
  - Inputs: acc, operand, opcode.
  - Outputs: result, carry, overflow, writes_acc, updates_cv.
- The top holds the registers, strobe edge detect, counter and output mux.

Test Plan:
- Reset hold and release with strobe=1 throughout, then a clock -> uo_out=0x00, view1=0x00, no execution (CNT stays 0).
- LOADI 0xF0, then ADD 0x20 -> ACC=0x10, C=1, V=0, Z=0, N=0; view1=0x22 (C=1, CNT=2).
- LOADI 0x7F, then ADD 0x01 -> ACC=0x80, N=1, V=1, C=0. Then SUB 0x80 -> ACC=0x00, Z=1, C=0, V=0.
- LOADI 0x05, then SUB 0x06 -> ACC=0xFF, C=1, N=1. Then XOR 0xFF -> ACC=0x00, Z=1, C still 1.
- LOADI 0xA5, STORE sel=2, LOADI 0x00, LOADR sel=2 -> ACC=0xA5; STORE leaves flags unchanged.
- Strobe held high for 5 cycles -> one execution. Strobe edge with ena=0 -> ACC unchanged. 16 executed commands -> CNT wraps to 0. uio_oe=0x00 at all times.
